// File: rtl/channel_sequencer.sv
// channel_sequencer
// Steps through a small pattern RAM and drives one synth channel. Each entry
// supplies the note and channel settings plus a length measured in tempo ticks.
//
// Ports:
//   clk50mhz, rst          : clock; synchronous active-high reset
//   wr_en/wr_addr/wr_data  : pattern RAM write port (usable in any state)
//   start, stop, loop      : playback control
//   tempo_div              : tick period minus one, in clk50mhz cycles
//   note_in .. fx_optB     : registered channel settings
//   note_clk, note_rst     : one-cycle tick and note-start pulses
//   playing, step, done    : playback status
module channel_sequencer #(
    parameter int TEMPO_W    = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk50mhz,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [20:0]           wr_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    input  logic [TEMPO_W-1:0]    tempo_div,
    output logic [5:0]            note_in,
    output logic [2:0]            note_length,
    output logic [1:0]            env_atk,
    output logic [1:0]            env_dec,
    output logic [1:0]            fx_sel,
    output logic [1:0]            fx_optA,
    output logic [1:0]            fx_optB,
    output logic                  note_clk,
    output logic                  note_rst,
    output logic                  playing,
    output logic [DEPTH_LOG2-1:0] step,
    output logic                  done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;
    localparam logic [1:0] PLAY  = 2'd3;

    localparam logic [DEPTH_LOG2-1:0] STEP_ONE = 1;
    localparam logic [TEMPO_W-1:0]    CNT_ONE  = 1;
    localparam logic [3:0]            TICK_ONE = 4'd1;

    logic [20:0]        mem [2**DEPTH_LOG2];
    logic [20:0]        entry;
    logic [1:0]         state;
    logic [TEMPO_W-1:0] cnt;
    logic [3:0]         ticks;

    // Pattern RAM has no reset so its contents survive rst.
    always_ff @(posedge clk50mhz) begin
        if (wr_en && !rst)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            state       <= IDLE;
            step        <= '0;
            entry       <= '0;
            cnt         <= '0;
            ticks       <= '0;
            note_in     <= '0;
            note_length <= '0;
            env_atk     <= '0;
            env_dec     <= '0;
            fx_sel      <= '0;
            fx_optA     <= '0;
            fx_optB     <= '0;
            note_clk    <= 1'b0;
            note_rst    <= 1'b0;
            playing     <= 1'b0;
            done        <= 1'b0;
        end else begin
            note_clk <= 1'b0;
            note_rst <= 1'b0;
            done     <= 1'b0;
            if (stop) begin
                // Channel settings are left as they are; only status drops.
                state   <= IDLE;
                playing <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            step    <= '0;
                            state   <= FETCH;
                            playing <= 1'b1;
                        end
                    end
                    FETCH: begin
                        entry <= mem[step];
                        state <= EMIT;
                    end
                    EMIT: begin
                        note_length <= entry[14:12];
                        env_atk     <= entry[11:10];
                        env_dec     <= entry[9:8];
                        fx_sel      <= entry[7:6];
                        fx_optA     <= entry[5:4];
                        fx_optB     <= entry[3:2];
                        // A rest keeps the previous note and does not retrigger.
                        if (!entry[1]) begin
                            note_in  <= entry[20:15];
                            note_rst <= 1'b1;
                        end
                        cnt   <= '0;
                        ticks <= '0;
                        state <= PLAY;
                    end
                    default: begin
                        // >= so a shrinking tempo_div cannot strand the counter.
                        if (cnt >= tempo_div) begin
                            cnt      <= '0;
                            note_clk <= 1'b1;
                            ticks    <= ticks + TICK_ONE;
                            // This wrap is tick number ticks+1; end on length+1.
                            if (ticks == {1'b0, entry[14:12]}) begin
                                if (entry[0] && !loop) begin
                                    state   <= IDLE;
                                    playing <= 1'b0;
                                    done    <= 1'b1;
                                end else begin
                                    state <= FETCH;
                                    // Last index wraps to 0 via natural overflow.
                                    step  <= entry[0] ? '0 : step + STEP_ONE;
                                end
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_channel_sequencer.sv
module tb_channel_sequencer;

    logic        clk50mhz = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [20:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [15:0] tempo_div = '0;
    logic [5:0]  note_in;
    logic [2:0]  note_length;
    logic [1:0]  env_atk, env_dec, fx_sel, fx_optA, fx_optB;
    logic        note_clk, note_rst, playing, done;
    logic [3:0]  step;

    channel_sequencer dut (
        .clk50mhz(clk50mhz), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .stop(stop), .loop(loop),
        .tempo_div(tempo_div), .note_in(note_in), .note_length(note_length),
        .env_atk(env_atk), .env_dec(env_dec), .fx_sel(fx_sel),
        .fx_optA(fx_optA), .fx_optB(fx_optB), .note_clk(note_clk),
        .note_rst(note_rst), .playing(playing), .step(step), .done(done)
    );

    always #5 clk50mhz = ~clk50mhz;

    int cyc = 0;
    always @(posedge clk50mhz) cyc <= cyc + 1;

    localparam int EV_RST = 0, EV_CLK = 1, EV_DONE = 2;
    typedef struct {int kind; int cyc; int note; int stp;} ev_t;
    ev_t q[$];

    logic [20:0] pat [16];
    int held_note = 0;
    int errs = 0, checks = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [20:0] ent(input int note, input int len, input int atk,
        input int dec, input int fx, input int oa, input int ob, input int rest, input int last);
        logic [20:0] w;
        w = {note[5:0], len[2:0], atk[1:0], dec[1:0], fx[1:0], oa[1:0], ob[1:0], rest[0], last[0]};
        return w;
    endfunction

    task automatic wr(input int a, input logic [20:0] d);
        @(negedge clk50mhz);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d;
        pat[a] = d;
        @(negedge clk50mhz);
        wr_en = 1'b0;
    endtask

    task automatic push(input int k, input int c, input int n, input int s);
        ev_t e;
        e.kind = k; e.cyc = c; e.note = n; e.stp = s;
        q.push_back(e);
    endtask

    // Expected pulse timeline: note_rst 2 cycles after the start edge (or after
    // the previous step's final tick), ticks every tempo+1 cycles, length+1 ticks.
    task automatic gen(input int e0, input int lim, input int tempo, input bit lp);
        int t, idx, len;
        logic [20:0] w;
        t = e0; idx = 0;
        for (int s = 0; s < 64; s++) begin
            if (t + 2 >= lim) break;
            w = pat[idx];
            len = int'(w[14:12]);
            if (!w[1]) begin
                held_note = int'(w[20:15]);
                push(EV_RST, t + 2, held_note, idx);
            end
            for (int k = 1; k <= len + 1; k++)
                if (t + 2 + k * (tempo + 1) < lim)
                    push(EV_CLK, t + 2 + k * (tempo + 1), held_note, idx);
            t = t + 2 + (len + 1) * (tempo + 1);
            if (w[0] && !lp) begin
                if (t < lim) push(EV_DONE, t, held_note, idx);
                break;
            end
            idx = (w[0] || idx == 15) ? 0 : idx + 1;
        end
    endtask

    // Every pulse the DUT produces must match the head of the scoreboard.
    task automatic pop_ev(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_pulse", kind, -1);
        end else begin
            e = q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_note", int'(note_in), e.note);
            if (kind == EV_RST) chk("ev_step", int'(step), e.stp);
            if (kind == EV_DONE) chk("done_playing", int'(playing), 0);
        end
    endtask

    always @(negedge clk50mhz) begin
        if (!rst) begin
            if (note_rst) pop_ev(EV_RST);
            if (note_clk) pop_ev(EV_CLK);
            if (done) pop_ev(EV_DONE);
        end
    end

    // horizon=0: run to completion; otherwise abort (stop or rst) at start+horizon.
    task automatic run(input int horizon, input bit use_rst);
        int e0;
        @(negedge clk50mhz);
        e0 = cyc + 1;
        gen(e0, horizon != 0 ? e0 + horizon : e0 + 100000, int'(tempo_div), loop);
        start = 1'b1;
        @(negedge clk50mhz);
        start = 1'b0;
        if (horizon != 0) begin
            while (cyc < e0 + horizon - 1) @(negedge clk50mhz);
            if (use_rst) rst = 1'b1; else stop = 1'b1;
            @(negedge clk50mhz);
            rst = 1'b0; stop = 1'b0;
            if (!use_rst) chk("stop_playing", int'(playing), 0);
            repeat (6) @(negedge clk50mhz);
        end else begin
            for (int i = 0; i < 2000 && (q.size() != 0 || playing); i++)
                @(negedge clk50mhz);
            @(negedge clk50mhz);
        end
        chk("sb_drained", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk50mhz);
        rst = 1'b0;
        @(negedge clk50mhz);
        chk("rst_note_in", int'(note_in), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_pulses", int'({note_clk, note_rst, done}), 0);

        // Two-entry pattern, single pass.
        wr(0, ent(12, 1, 0, 0, 0, 0, 0, 0, 0));
        wr(1, ent(20, 0, 0, 0, 0, 0, 0, 0, 1));
        tempo_div = 16'd3; loop = 1'b0;
        run(0, 1'b0);
        chk("end_note", int'(note_in), 20);

        // Same pattern looping: returns to entry 0, aborted by stop.
        loop = 1'b1;
        run(40, 1'b0);
        chk("loop_held_note", int'(note_in), held_note);

        // Rest entry: no retrigger, note held, settings update.
        loop = 1'b0;
        wr(1, ent(20, 0, 2, 1, 3, 1, 2, 1, 1));
        run(0, 1'b0);
        chk("rest_note_held", int'(note_in), 12);
        chk("rest_fx_sel", int'(fx_sel), 3);
        chk("rest_fx_optA", int'(fx_optA), 1);
        chk("rest_fx_optB", int'(fx_optB), 2);
        chk("rest_env_atk", int'(env_atk), 2);
        chk("rest_env_dec", int'(env_dec), 1);

        // Stop during entry 0, outputs held, then restart from step 0.
        wr(1, ent(20, 0, 0, 0, 0, 0, 0, 0, 1));
        run(5, 1'b0);
        chk("stop_note_held", int'(note_in), 12);
        chk("stop_len_held", int'(note_length), 1);
        run(0, 1'b0);

        // start and stop together in IDLE: nothing happens.
        @(negedge clk50mhz);
        start = 1'b1; stop = 1'b1;
        @(negedge clk50mhz);
        start = 1'b0; stop = 1'b0;
        repeat (4) @(negedge clk50mhz);
        chk("startstop_idle", int'(playing), 0);

        // Reset mid-playback clears outputs; RAM survives.
        run(8, 1'b1);
        held_note = 0;
        chk("midrst_note_in", int'(note_in), 0);
        chk("midrst_len", int'(note_length), 0);
        chk("midrst_playing", int'(playing), 0);
        chk("midrst_step", int'(step), 0);
        run(0, 1'b0);

        // Full table at tempo 0: tick every cycle, wrap after entry 15.
        for (int i = 0; i < 16; i++) wr(i, ent(i + 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tempo_div = 16'd0;
        run(56, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
